// File: rtl/bfloat_pkg.sv
// bfloat_pkg: shared bfloat16 types, constants and helpers for the adder/subtractor.
// Layout: sign[15], exp[14:7], mant[6:0].
package bfloat_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 7;
  localparam int unsigned GRS_W  = 3;

  // Working significand: hidden bit + stored mantissa + guard/round/sticky
  localparam int unsigned SIG_W  = MANT_W + GRS_W + 1;
  // Sum carries one extra bit for the carry out of the add
  localparam int unsigned SUM_W  = MANT_W + GRS_W + 2;
  // Working exponent with headroom for the carry step and rounding
  localparam int unsigned WEXP_W = EXP_W + 2;
  // Alignment shift amount width
  localparam int unsigned SH_W   = $clog2(SIG_W);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } bf16_t;

  localparam logic [15:0]      BF16_QNAN = 16'h7FC0;
  localparam logic [15:0]      BF16_PINF = 16'h7F80;
  localparam logic [15:0]      BF16_NINF = 16'hFF80;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ADD    = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_DONE   = 3'd6
  } sub_state_e;

  function automatic logic bf_is_nan(input bf16_t v);
    return (v.exp == EXP_MAX) && (v.mant != '0);
  endfunction

  function automatic logic bf_is_inf(input bf16_t v);
    return (v.exp == EXP_MAX) && (v.mant == '0);
  endfunction

endpackage

// File: rtl/bfloat_rounder.sv
// bfloat_rounder: combinational final rounding and packing of a normalised result.
// Ports:
//   i_sign  result sign
//   i_exp   working exponent (0 means the result is a signed zero)
//   i_mant  stored mantissa bits (hidden bit excluded)
//   i_grs   guard/round/sticky bits
//   o_res_c packed bfloat16 result
//   o_ovf_c result overflowed to signed infinity
// Build option: BFLOAT_SUB_RNE_EN selects round-to-nearest-even, otherwise truncate.
module bfloat_rounder
  import bfloat_pkg::*;
(
  input  logic              i_sign,
  input  logic [WEXP_W-1:0] i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [GRS_W-1:0]  i_grs,
  output logic [15:0]       o_res_c,
  output logic              o_ovf_c
);

  logic              w_up;
  logic [MANT_W:0]   w_mant_r;
  logic [WEXP_W-1:0] w_exp_r;

`ifdef BFLOAT_SUB_RNE_EN
  // Round up above half, or exactly half with an odd mantissa
  assign w_up = i_grs[GRS_W-1] & ((|i_grs[GRS_W-2:0]) | i_mant[0]);
`else
  assign w_up = 1'b0 & (|i_grs);
`endif

  assign w_mant_r = {1'b0, i_mant} + (MANT_W+1)'(w_up);
  // Mantissa wrap from rounding bumps the exponent; stored bits are already zero
  assign w_exp_r  = i_exp + WEXP_W'(w_mant_r[MANT_W]);

  always_comb begin
    o_ovf_c = 1'b0;
    o_res_c = {i_sign, w_exp_r[EXP_W-1:0], w_mant_r[MANT_W-1:0]};
    if (i_exp == '0) begin
      o_res_c = {i_sign, 15'h0000};
    end else if (w_exp_r >= WEXP_W'(EXP_MAX)) begin
      o_res_c = {i_sign, EXP_MAX, MANT_W'(0)};
      o_ovf_c = 1'b1;
    end
  end

endmodule

// File: rtl/bfloat_subtractor_seq.sv
// bfloat_subtractor_seq: multi-cycle bfloat16 subtractor, c = a - b.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a minuend, b subtrahend)
//   out_valid / out_ready result handshake (c, out_ovf, out_inv)
// Flow: IDLE -> UNPACK -> ALIGN -> ADD -> NORM (1 step per cycle) -> ROUND -> DONE.
// Build option: BFLOAT_SUB_RNE_EN enables round-to-nearest-even in the rounder.
module bfloat_subtractor_seq
  import bfloat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        out_ovf,
  output logic        out_inv
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_UNPACK = ST_UNPACK;
  localparam logic [2:0] S_ALIGN  = ST_ALIGN;
  localparam logic [2:0] S_ADD    = ST_ADD;
  localparam logic [2:0] S_NORM   = ST_NORM;
  localparam logic [2:0] S_ROUND  = ST_ROUND;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]        r_state,     w_state_nxt;
  bf16_t             r_a,         w_a_nxt;
  bf16_t             r_b,         w_b_nxt;
  logic              r_xs,        w_xs_nxt;
  logic [EXP_W-1:0]  r_xe,        w_xe_nxt;
  logic [SIG_W-1:0]  r_xm,        w_xm_nxt;
  logic              r_ys,        w_ys_nxt;
  logic [EXP_W-1:0]  r_ye,        w_ye_nxt;
  logic [SIG_W-1:0]  r_ym,        w_ym_nxt;
  logic              r_sign,      w_sign_nxt;
  logic [WEXP_W-1:0] r_exp,       w_exp_nxt;
  logic [SUM_W-1:0]  r_sum,       w_sum_nxt;
  logic [15:0]       r_c,         w_c_nxt;
  logic              r_ovf,       w_ovf_nxt;
  logic              r_inv,       w_inv_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_in_ready,  w_in_ready_nxt;

  // Unpack: classify operands, flush subnormals to signed zero
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [SIG_W-1:0] w_a_sig, w_b_sig;

  assign w_a_nan = bf_is_nan(r_a);
  assign w_b_nan = bf_is_nan(r_b);
  assign w_a_inf = bf_is_inf(r_a);
  assign w_b_inf = bf_is_inf(r_b);
  assign w_a_exp = r_a.exp;
  assign w_b_exp = r_b.exp;
  assign w_a_sig = (r_a.exp == '0) ? '0 : {1'b1, r_a.mant, GRS_W'(0)};
  assign w_b_sig = (r_b.exp == '0) ? '0 : {1'b1, r_b.mant, GRS_W'(0)};

  // Align: order by magnitude, then shift the smaller with sticky collection
  logic             w_swap;
  logic             w_bx_s, w_by_s;
  logic [EXP_W-1:0] w_bx_e, w_by_e, w_diff;
  logic [SIG_W-1:0] w_bx_m, w_by_m, w_y_al, w_lost;

  assign w_swap = {r_ye, r_ym} > {r_xe, r_xm};
  assign w_bx_s = w_swap ? r_ys : r_xs;
  assign w_bx_e = w_swap ? r_ye : r_xe;
  assign w_bx_m = w_swap ? r_ym : r_xm;
  assign w_by_s = w_swap ? r_xs : r_ys;
  assign w_by_e = w_swap ? r_xe : r_ye;
  assign w_by_m = w_swap ? r_xm : r_ym;
  assign w_diff = w_bx_e - w_by_e;

  always_comb begin
    w_lost = '0;
    w_y_al = '0;
    if (w_diff > EXP_W'(SIG_W - 1)) begin
      w_y_al = SIG_W'(|w_by_m);
    end else begin
      w_lost = w_by_m & ~({SIG_W{1'b1}} << w_diff[SH_W-1:0]);
      w_y_al = w_by_m >> w_diff[SH_W-1:0];
      w_y_al[0] = w_y_al[0] | (|w_lost);
    end
  end

  // Add: |x| >= |y| so the effective subtraction never goes negative
  logic [SUM_W-1:0] w_sum;
  assign w_sum = (r_xs == r_ys) ? (SUM_W'(r_xm) + SUM_W'(r_ym))
                                : (SUM_W'(r_xm) - SUM_W'(r_ym));

  logic [15:0] w_rnd_res_c;
  logic        w_rnd_ovf_c;

  bfloat_rounder u_rounder (
    .i_sign  (r_sign),
    .i_exp   (r_exp),
    .i_mant  (r_sum[SIG_W-2:GRS_W]),
    .i_grs   (r_sum[GRS_W-1:0]),
    .o_res_c (w_rnd_res_c),
    .o_ovf_c (w_rnd_ovf_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_xs        <= 1'b0;
      r_xe        <= '0;
      r_xm        <= '0;
      r_ys        <= 1'b0;
      r_ye        <= '0;
      r_ym        <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sum       <= '0;
      r_c         <= 16'h0000;
      r_ovf       <= 1'b0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_xs        <= w_xs_nxt;
      r_xe        <= w_xe_nxt;
      r_xm        <= w_xm_nxt;
      r_ys        <= w_ys_nxt;
      r_ye        <= w_ye_nxt;
      r_ym        <= w_ym_nxt;
      r_sign      <= w_sign_nxt;
      r_exp       <= w_exp_nxt;
      r_sum       <= w_sum_nxt;
      r_c         <= w_c_nxt;
      r_ovf       <= w_ovf_nxt;
      r_inv       <= w_inv_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_xs_nxt        = r_xs;
    w_xe_nxt        = r_xe;
    w_xm_nxt        = r_xm;
    w_ys_nxt        = r_ys;
    w_ye_nxt        = r_ye;
    w_ym_nxt        = r_ym;
    w_sign_nxt      = r_sign;
    w_exp_nxt       = r_exp;
    w_sum_nxt       = r_sum;
    w_c_nxt         = r_c;
    w_ovf_nxt       = r_ovf;
    w_inv_nxt       = r_inv;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          // Subtraction is addition of b with its sign flipped
          w_a_nxt     = bf16_t'(a);
          w_b_nxt     = bf16_t'({~b[15], b[14:0]});
          w_ovf_nxt   = 1'b0;
          w_inv_nxt   = 1'b0;
          w_state_nxt = S_UNPACK;
        end
      end

      S_UNPACK: begin
        // Opposite effective signs here means inf - inf of the same original sign
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a.sign != r_b.sign))) begin
          w_c_nxt         = BF16_QNAN;
          w_inv_nxt       = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (w_a_inf) begin
          w_c_nxt         = r_a;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (w_b_inf) begin
          w_c_nxt         = r_b;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_xs_nxt    = r_a.sign;
          w_xe_nxt    = w_a_exp;
          w_xm_nxt    = w_a_sig;
          w_ys_nxt    = r_b.sign;
          w_ye_nxt    = w_b_exp;
          w_ym_nxt    = w_b_sig;
          w_state_nxt = S_ALIGN;
        end
      end

      S_ALIGN: begin
        w_xs_nxt    = w_bx_s;
        w_xe_nxt    = w_bx_e;
        w_xm_nxt    = w_bx_m;
        w_ys_nxt    = w_by_s;
        w_ye_nxt    = w_by_e;
        w_ym_nxt    = w_y_al;
        w_state_nxt = S_ADD;
      end

      S_ADD: begin
        w_sum_nxt   = w_sum;
        w_sign_nxt  = r_xs;
        w_exp_nxt   = WEXP_W'(r_xe);
        w_state_nxt = S_NORM;
      end

      S_NORM: begin
        if (r_sum[SUM_W-1]) begin
          // Carry out: shift right keeping the dropped bit as sticky
          w_sum_nxt = {1'b0, r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
          w_exp_nxt = r_exp + WEXP_W'(1);
        end else if (r_sum == '0) begin
          w_sign_nxt  = 1'b0;
          w_exp_nxt   = '0;
          w_state_nxt = S_ROUND;
        end else if (!r_sum[SUM_W-2]) begin
          if (r_exp <= WEXP_W'(1)) begin
            // Underflow: exponent 0 tells the rounder to emit signed zero
            w_exp_nxt   = '0;
            w_state_nxt = S_ROUND;
          end else begin
            w_sum_nxt = r_sum << 1;
            w_exp_nxt = r_exp - WEXP_W'(1);
          end
        end else begin
          w_state_nxt = S_ROUND;
        end
      end

      S_ROUND: begin
        w_c_nxt         = w_rnd_res_c;
        w_ovf_nxt       = w_rnd_ovf_c;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign out_ovf   = r_ovf;
  assign out_inv   = r_inv;

endmodule
